// File: rtl/digit_entry_ctrl_if.sv
// Bundle of the front-panel key/rotary inputs and the digit-buffer outputs.
//   master : drives i_key0, i_key1, i_rotary; observes the o_* outputs
//   slave  : digit_entry_ctrl side
// Signals:
//   i_key0        raw ENTER pushbutton, active-low
//   i_key1        raw CLEAR pushbutton, active-low
//   i_rotary      raw rotary hex switch value
//   o_digits      digit nibbles, [3:0] = newest (rightmost) digit
//   o_digit_valid bit i set when nibble i holds an entered digit
//   o_count       number of entered digits
//   o_full        buffer holds NUM_DIGITS digits
//   o_press       1-cycle pulse, digit accepted
//   o_reject      1-cycle pulse, ENTER pressed while full
interface digit_entry_ctrl_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    i_key0;
  logic                    i_key1;
  logic [3:0]              i_rotary;
  logic [4*NUM_DIGITS-1:0] o_digits;
  logic [NUM_DIGITS-1:0]   o_digit_valid;
  logic [3:0]              o_count;
  logic                    o_full;
  logic                    o_press;
  logic                    o_reject;

  modport master (
    output i_key0, i_key1, i_rotary,
    input  o_digits, o_digit_valid, o_count, o_full, o_press, o_reject
  );

  modport slave (
    input  i_key0, i_key1, i_rotary,
    output o_digits, o_digit_valid, o_count, o_full, o_press, o_reject
  );
endinterface

// File: rtl/digit_entry_ctrl.sv
// Front-panel digit entry stage feeding the 7-segment display digit inputs.
// Two raw active-low pushbuttons are synchronised, debounced and edge
// detected. Each accepted ENTER (key0) press shifts the synchronised rotary
// switch value into an N-digit nibble buffer; CLEAR (key1) empties it.
// Ports:
//   i_clk  system clock
//   i_rst  synchronous reset, active-high
//   bus    digit_entry_ctrl_if.slave (keys, rotary, digit buffer, status)
// NUM_DIGITS must be in 2..8 (o_count is 4 bits wide).
module digit_entry_ctrl #(
  parameter int DEB_CNT    = 10000,
  parameter int NUM_DIGITS = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  digit_entry_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(DEB_CNT + 1);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ENTRY,
    ST_FULL
  } state_t;

  // index 0 = ENTER (key0), index 1 = CLEAR (key1)
  logic [1:0]       key_raw;
  logic             key_meta_q       [2];
  logic             key_sync_q       [2];
  logic             key_stable_q     [2];
  logic             key_stable_dly_q [2];
  logic [CNT_W-1:0] deb_cnt_q        [2];
  logic [1:0]       press_evt;

  logic [3:0]       rot_meta_q;
  logic [3:0]       rot_sync_q;

  state_t                  state_q;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   valid_q;
  logic [3:0]              count_q;
  logic                    full_q;
  logic                    press_q;
  logic                    reject_q;

  assign key_raw = {bus.i_key1, bus.i_key0};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_key
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          key_meta_q[gi]       <= 1'b1;
          key_sync_q[gi]       <= 1'b1;
          key_stable_q[gi]     <= 1'b1;
          key_stable_dly_q[gi] <= 1'b1;
          deb_cnt_q[gi]        <= '0;
        end else begin
          key_meta_q[gi]       <= key_raw[gi];
          key_sync_q[gi]       <= key_meta_q[gi];
          key_stable_dly_q[gi] <= key_stable_q[gi];
          if (key_sync_q[gi] != key_stable_q[gi]) begin
            if (deb_cnt_q[gi] == CNT_W'(DEB_CNT - 1)) begin
              key_stable_q[gi] <= key_sync_q[gi];
              deb_cnt_q[gi]    <= '0;
            end else begin
              deb_cnt_q[gi] <= deb_cnt_q[gi] + 1'b1;
            end
          end else begin
            // any bounce back to the accepted level restarts the count
            deb_cnt_q[gi] <= '0;
          end
        end
      end

      // Press is taken from the delayed copy so the buffer update lands one
      // edge after the debounced level flips; releases are ignored.
      assign press_evt[gi] = key_stable_dly_q[gi] & ~key_stable_q[gi];
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rot_meta_q <= '0;
      rot_sync_q <= '0;
    end else begin
      rot_meta_q <= bus.i_rotary;
      rot_sync_q <= rot_meta_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_EMPTY;
      digits_q <= '0;
      valid_q  <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      press_q  <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      press_q  <= 1'b0;
      reject_q <= 1'b0;
      if (press_evt[1]) begin
        // CLEAR takes priority and swallows a simultaneous ENTER
        state_q  <= ST_EMPTY;
        digits_q <= '0;
        valid_q  <= '0;
        count_q  <= '0;
        full_q   <= 1'b0;
      end else if (press_evt[0]) begin
        if (state_q == ST_FULL) begin
          reject_q <= 1'b1;
        end else begin
          digits_q <= {digits_q[4*NUM_DIGITS-5:0], rot_sync_q};
          valid_q  <= {valid_q[NUM_DIGITS-2:0], 1'b1};
          count_q  <= count_q + 4'd1;
          press_q  <= 1'b1;
          if (count_q == 4'(NUM_DIGITS - 1)) begin
            state_q <= ST_FULL;
            full_q  <= 1'b1;
          end else begin
            state_q <= ST_ENTRY;
          end
        end
      end
    end
  end

  assign bus.o_digits      = digits_q;
  assign bus.o_digit_valid = valid_q;
  assign bus.o_count       = count_q;
  assign bus.o_full        = full_q;
  assign bus.o_press       = press_q;
  assign bus.o_reject      = reject_q;

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Directed bench for digit_entry_ctrl with DEB_CNT = 4, NUM_DIGITS = 8.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Edge 0 of a window is the first edge that samples the newly driven level.
module tb_digit_entry_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  digit_entry_ctrl_if #(.NUM_DIGITS(8)) bus ();

  digit_entry_ctrl #(
    .DEB_CNT   (4),
    .NUM_DIGITS(8)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps n edges, counting output pulses and remembering the first press edge.
  task automatic run_window(input int n, output int npress, output int nrej,
                            output int first_edge, output int nboth);
    npress = 0; nrej = 0; first_edge = -1; nboth = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (bus.o_press === 1'b1) begin
        npress++;
        if (first_edge < 0) first_edge = k;
      end
      if (bus.o_reject === 1'b1) nrej++;
      if (bus.o_press === 1'b1 && bus.o_reject === 1'b1) nboth++;
    end
  endtask

  // Presses the selected keys for 10 cycles and releases them for 10 cycles.
  task automatic press_keys(input logic k0, input logic k1,
                            output int npress, output int nrej, output int nboth);
    int p2, r2, f, b2;
    bus.i_key0 = ~k0;
    bus.i_key1 = ~k1;
    run_window(10, npress, nrej, f, nboth);
    bus.i_key0 = 1'b1;
    bus.i_key1 = 1'b1;
    run_window(10, p2, r2, f, b2);
    npress += p2; nrej += r2; nboth += b2;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.i_key0 = 1'b1;
    bus.i_key1 = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_reset();
    int np, nr, fe, nb;
    rst = 1'b1;
    bus.i_key0 = 1'b0;
    bus.i_key1 = 1'b1;
    bus.i_rotary = 4'h0;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if ({bus.o_digits, bus.o_digit_valid, bus.o_count, bus.o_full, bus.o_press, bus.o_reject} !== '0) begin
        bad++;
        $display("FAIL reset_outputs cycle %0d: digits=%h valid=%h count=%0d full=%b press=%b reject=%b required all 0",
                 k, bus.o_digits, bus.o_digit_valid, bus.o_count, bus.o_full, bus.o_press, bus.o_reject);
      end
    end
    rst = 1'b0;
    run_window(12, np, nr, fe, nb);
    total++;
    if (np !== 1 || fe !== 6) begin
      bad++;
      $display("FAIL reset_held_key: presses=%0d at edge %0d, required 1 at edge 6", np, fe);
    end
    $display("test_reset: presses=%0d first_edge=%0d", np, fe);
    bus.i_key0 = 1'b1;
    repeat (10) step();
  endtask

  task automatic test_single_press();
    int np, nr, fe, nb;
    apply_reset();
    bus.i_rotary = 4'h5;
    repeat (3) step();
    bus.i_key0 = 1'b0;
    run_window(20, np, nr, fe, nb);
    total++;
    if (np !== 1 || fe !== 6) begin
      bad++;
      $display("FAIL single_press: presses=%0d at edge %0d, required 1 at edge 6", np, fe);
    end
    total++;
    if (bus.o_digits !== 32'h0000_0005 || bus.o_digit_valid !== 8'h01 || bus.o_count !== 4'd1) begin
      bad++;
      $display("FAIL single_buffer: digits=%h valid=%h count=%0d, required 00000005 01 1",
               bus.o_digits, bus.o_digit_valid, bus.o_count);
    end
    $display("test_single_press: digits=%h valid=%h count=%0d", bus.o_digits, bus.o_digit_valid, bus.o_count);
    bus.i_key0 = 1'b1;
    repeat (10) step();
  endtask

  task automatic test_chatter();
    int np, nr, fe, nb, tot_p;
    tot_p = 0;
    bus.i_rotary = 4'hA;
    for (int r = 0; r < 4; r++) begin
      bus.i_key0 = 1'b0;
      run_window(3, np, nr, fe, nb);
      tot_p += np;
      bus.i_key0 = 1'b1;
      run_window(1, np, nr, fe, nb);
      tot_p += np;
    end
    total++;
    if (tot_p !== 0) begin
      bad++;
      $display("FAIL chatter_no_press: presses=%0d required 0", tot_p);
    end
    bus.i_key0 = 1'b0;
    run_window(20, np, nr, fe, nb);
    total++;
    if (np !== 1) begin
      bad++;
      $display("FAIL chatter_then_hold: presses=%0d required 1", np);
    end
    total++;
    if (bus.o_digits !== 32'h0000_005A || bus.o_count !== 4'd2) begin
      bad++;
      $display("FAIL chatter_buffer: digits=%h count=%0d required 0000005a 2", bus.o_digits, bus.o_count);
    end
    $display("test_chatter: chatter_presses=%0d hold_presses=%0d digits=%h", tot_p, np, bus.o_digits);
    bus.i_key0 = 1'b1;
    repeat (10) step();
  endtask

  task automatic test_fill_and_reject();
    int np, nr, nb;
    apply_reset();
    for (int d = 1; d <= 8; d++) begin
      bus.i_rotary = 4'(d);
      press_keys(1'b1, 1'b0, np, nr, nb);
      total++;
      if (np !== 1 || nr !== 0 || bus.o_count !== 4'(d)) begin
        bad++;
        $display("FAIL fill_digit_%0d: presses=%0d rejects=%0d count=%0d required 1 0 %0d", d, np, nr, bus.o_count, d);
      end
    end
    total++;
    if (bus.o_digits !== 32'h1234_5678 || bus.o_count !== 4'd8 || bus.o_full !== 1'b1 || bus.o_digit_valid !== 8'hFF) begin
      bad++;
      $display("FAIL fill_full: digits=%h count=%0d full=%b valid=%h required 12345678 8 1 ff",
               bus.o_digits, bus.o_count, bus.o_full, bus.o_digit_valid);
    end
    bus.i_rotary = 4'h9;
    press_keys(1'b1, 1'b0, np, nr, nb);
    total++;
    if (nr !== 1 || np !== 0 || nb !== 0) begin
      bad++;
      $display("FAIL reject_pulse: rejects=%0d presses=%0d both=%0d required 1 0 0", nr, np, nb);
    end
    total++;
    if (bus.o_digits !== 32'h1234_5678 || bus.o_count !== 4'd8 || bus.o_full !== 1'b1 || bus.o_digit_valid !== 8'hFF) begin
      bad++;
      $display("FAIL reject_unchanged: digits=%h count=%0d full=%b valid=%h required 12345678 8 1 ff",
               bus.o_digits, bus.o_count, bus.o_full, bus.o_digit_valid);
    end
    $display("test_fill_and_reject: digits=%h count=%0d full=%b rejects=%0d", bus.o_digits, bus.o_count, bus.o_full, nr);
  endtask

  task automatic test_clear_wins();
    int np, nr, nb;
    apply_reset();
    for (int d = 0; d < 3; d++) begin
      bus.i_rotary = 4'(d + 3);
      press_keys(1'b1, 1'b0, np, nr, nb);
    end
    total++;
    if (bus.o_digits !== 32'h0000_0345 || bus.o_count !== 4'd3) begin
      bad++;
      $display("FAIL clear_setup: digits=%h count=%0d required 00000345 3", bus.o_digits, bus.o_count);
    end
    press_keys(1'b1, 1'b1, np, nr, nb);
    total++;
    if (np !== 0 || nr !== 0) begin
      bad++;
      $display("FAIL clear_no_pulse: presses=%0d rejects=%0d required 0 0", np, nr);
    end
    total++;
    if (bus.o_digits !== '0 || bus.o_digit_valid !== '0 || bus.o_count !== 4'd0 || bus.o_full !== 1'b0) begin
      bad++;
      $display("FAIL clear_buffer: digits=%h valid=%h count=%0d full=%b required all 0",
               bus.o_digits, bus.o_digit_valid, bus.o_count, bus.o_full);
    end
    $display("test_clear_wins: presses=%0d rejects=%0d count=%0d", np, nr, bus.o_count);
  endtask

  task automatic test_reset_mid_debounce();
    int np, nr, fe, nb;
    apply_reset();
    bus.i_rotary = 4'hC;
    press_keys(1'b1, 1'b0, np, nr, nb);
    bus.i_rotary = 4'h7;
    bus.i_key0 = 1'b0;
    run_window(4, np, nr, fe, nb);   // edges 0..3: counter reaches 2
    total++;
    if (np !== 0) begin
      bad++;
      $display("FAIL middeb_early: presses=%0d required 0", np);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({bus.o_digits, bus.o_digit_valid, bus.o_count, bus.o_full, bus.o_press, bus.o_reject} !== '0) begin
      bad++;
      $display("FAIL middeb_reset_outputs: digits=%h valid=%h count=%0d full=%b required all 0",
               bus.o_digits, bus.o_digit_valid, bus.o_count, bus.o_full);
    end
    run_window(12, np, nr, fe, nb);
    total++;
    if (np !== 1 || fe !== 6) begin
      bad++;
      $display("FAIL middeb_restart: presses=%0d at edge %0d, required 1 at edge 6", np, fe);
    end
    total++;
    if (bus.o_digits !== 32'h0000_0007 || bus.o_count !== 4'd1) begin
      bad++;
      $display("FAIL middeb_buffer: digits=%h count=%0d required 00000007 1", bus.o_digits, bus.o_count);
    end
    $display("test_reset_mid_debounce: presses=%0d first_edge=%0d digits=%h", np, fe, bus.o_digits);
    bus.i_key0 = 1'b1;
    repeat (10) step();
  endtask

  initial begin
    rst = 1'b1;
    bus.i_key0 = 1'b1;
    bus.i_key1 = 1'b1;
    bus.i_rotary = 4'h0;
    test_reset();
    test_single_press();
    test_chatter();
    test_fill_and_reject();
    test_clear_wins();
    test_reset_mid_debounce();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
